// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter. Frame: start 0, DATA_W bits LSB first, stop 1.
// Define PISO_TX_PARITY_EN to insert an even-parity bit between the last data bit and stop.
module piso_tx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              ser_out,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

`ifdef PISO_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              ser_q, ser_d;
  logic              accept;
`ifdef PISO_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  assign tx_ready = (state_q == IDLE) || (state_q == STOP);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == STOP) && en;
  assign ser_out  = ser_q;
  assign accept   = tx_valid && tx_ready && en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      shift_q  <= '0;
      ser_q    <= 1'b1;
`ifdef PISO_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      ser_q    <= ser_d;
`ifdef PISO_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // ser_out is registered with the value of the bit belonging to the next state,
  // so the line level always lines up with the state it is shown in.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    ser_d    = ser_q;
`ifdef PISO_TX_PARITY_EN
    parity_d = parity_q;
`endif
    if (en) begin
      unique case (state_q)
        IDLE, STOP: begin
          if (accept) begin
            state_d  = START;
            ser_d    = 1'b0;
            shift_d  = tx_data;
            cnt_d    = '0;
`ifdef PISO_TX_PARITY_EN
            parity_d = ^tx_data;
`endif
          end else begin
            state_d = IDLE;
            ser_d   = 1'b1;
          end
        end
        START: begin
          state_d = DATA;
          ser_d   = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = '0;
        end
        DATA: begin
          if (cnt_q == LAST_BIT) begin
            cnt_d = '0;
`ifdef PISO_TX_PARITY_EN
            state_d = PARITY;
            ser_d   = parity_q;
`else
            state_d = STOP;
            ser_d   = 1'b1;
`endif
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            ser_d   = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
`ifdef PISO_TX_PARITY_EN
        PARITY: begin
          state_d = STOP;
          ser_d   = 1'b1;
        end
`endif
        default: begin
          state_d = IDLE;
          ser_d   = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx (DATA_W=8); honours PISO_TX_PARITY_EN when defined.
module tb_piso_tx;
  localparam int DW = 8;
`ifdef PISO_TX_PARITY_EN
  localparam int FL = DW + 3;
  localparam bit EXP_A5 [FL] = '{0,1,0,1,0,0,1,0,1,0,1};
  localparam bit EXP_3C [FL] = '{0,0,0,1,1,1,1,0,0,0,1};
  localparam bit EXP_81 [FL] = '{0,1,0,0,0,0,0,0,1,0,1};
  localparam bit EXP_BB [2*FL] = '{0,0,0,0,0,0,0,0,0,0,1, 0,1,1,1,1,1,1,1,1,0,1};
`else
  localparam int FL = DW + 2;
  localparam bit EXP_A5 [FL] = '{0,1,0,1,0,0,1,0,1,1};
  localparam bit EXP_3C [FL] = '{0,0,0,1,1,1,1,0,0,1};
  localparam bit EXP_81 [FL] = '{0,1,0,0,0,0,0,0,1,1};
  localparam bit EXP_BB [2*FL] = '{0,0,0,0,0,0,0,0,0,1, 0,1,1,1,1,1,1,1,1,1};
`endif

  logic          clk;
  logic          reset_n;
  logic          en;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          ser_out;
  logic          busy;
  logic          done;

  int n_pass  = 0;
  int n_total = 0;

  piso_tx #(.DATA_W(DW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .ser_out  (ser_out),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: queue of line bits still to be shown for the frame in flight; head is current bit.
  bit q[$];
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
    end else if (en) begin
      if (tx_valid && q.size() <= 1) begin
        q.delete();
        q.push_back(1'b0);
        for (int b = 0; b < DW; b++) q.push_back(tx_data[b]);
`ifdef PISO_TX_PARITY_EN
        q.push_back(^tx_data);
`endif
        q.push_back(1'b1);
      end else if (q.size() > 0) begin
        void'(q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    check("ser_out",  ser_out,  (q.size() == 0) ? 1'b1 : q[0]);
    check("busy",     busy,     q.size() != 0);
    check("tx_ready", tx_ready, q.size() <= 1);
    check("done",     done,     (q.size() == 1) && en);
  end

  task automatic tick(input logic e, input logic v, input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    en = e; tx_valid = v; tx_data = d;
    #1;
  endtask

  initial begin
    int ndone;
    reset_n = 1'b0; en = 1'b0; tx_valid = 1'b0; tx_data = '0;
    #12;
    check("rst_ser", ser_out, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ready", tx_ready, 1'b1);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    tick(0, 0, '0);

    // 0xA5 with en held high; model contents pinned to the literal frame
    tick(1, 1, 8'hA5);
    for (int i = 0; i < FL; i++) begin
      tick(1, 0, '0);
      if (i == 0) begin
        check("model_len", q.size(), FL);
        for (int k = 0; k < FL; k++) check("model_a5", q[k], EXP_A5[k]);
      end
      check("a5_bit", ser_out, EXP_A5[i]);
      check("a5_done", done, i == FL - 1);
    end
    tick(1, 0, '0);
    check("a5_busy_after", busy, 1'b0);
    check("a5_idle_line", ser_out, 1'b1);

`ifdef PISO_TX_PARITY_EN
    tick(1, 1, 8'h01);
    for (int i = 0; i < FL; i++) begin
      tick(1, 0, '0);
      if (i == FL - 2) check("par01_bit", ser_out, 1'b1);
    end
    tick(1, 0, '0);
`endif

    // back-to-back 0x00 then 0xFF, tx_valid held until the STOP edge
    tick(1, 1, 8'h00);
    for (int i = 0; i < 2 * FL; i++) begin
      tick(1, i <= FL - 1, 8'hFF);
      check("bb_bit", ser_out, EXP_BB[i]);
      check("bb_busy", busy, 1'b1);
    end
    tick(1, 0, '0);
    check("bb_busy_after", busy, 1'b0);

    // en toggling: each bit held two clocks, done for exactly one clock
    tick(1, 1, 8'h3C);
    ndone = 0;
    for (int i = 0; i < 2 * FL; i++) begin
      tick(logic'(i % 2), 0, '0);
      check("en_bit", ser_out, EXP_3C[i / 2]);
      if (done) ndone++;
    end
    check("en_done_count", ndone, 1);
    tick(1, 0, '0);
    check("en_busy_after", busy, 1'b0);

    // reset during data bit 4 of 0x5A, then 0x81 goes out clean
    tick(1, 1, 8'h5A);
    for (int i = 0; i <= 5; i++) tick(1, 0, '0);
    check("rst_mid_bit4", ser_out, 1'b1);
    check("rst_mid_busy_pre", busy, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    check("rst_mid_ser", ser_out, 1'b1);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_done", done, 1'b0);
    tick(1, 0, '0);
    reset_n = 1'b1;
    tick(1, 0, '0);
    check("post_rst_idle", busy, 1'b0);
    tick(1, 1, 8'h81);
    for (int i = 0; i < FL; i++) begin
      tick(1, 0, '0);
      check("w81_bit", ser_out, EXP_81[i]);
    end
    tick(1, 0, '0);

    // tx_valid raised during DATA is ignored until the STOP cycle
    tick(1, 1, 8'h11);
    for (int i = 0; i < FL; i++) begin
      tick(1, i >= 1, 8'hC3);
      if (i >= 1 && i <= FL - 2) check("data_ready_low", tx_ready, 1'b0);
      if (i == FL - 1) check("stop_ready_high", tx_ready, 1'b1);
    end
    tick(1, 0, '0);
    check("stop_accept_start", ser_out, 1'b0);
    check("stop_accept_busy", busy, 1'b1);
    for (int i = 1; i < FL; i++) tick(1, 0, '0);
    tick(1, 0, '0);
    check("final_idle", busy, 1'b0);

    tick(0, 0, '0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
